clk_ctrl: RTL and testbench
===========================

# clk_ctrl

Run/stop/single-step controller for the CPU clock divider. Holds a runtime-programmable divisor, emits a one-cycle clock-enable `tick` plus a 50 % duty square wave `out`, and sequences free-run, graceful stop and single-step so the CPU can be halted or stepped from switches or a debug port. It sits between the board clock/reset and every block that advances on the divided CPU clock.

## Interface
- `WIDTH`, 32: width of divisor, period counter and tick counter.
- `DEFAULT_DIV`, 25_000_000: divisor loaded at reset (tick period in `clk` cycles).

- `clk`  in  1: board clock; all state on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `run`  in  1: level; 1 = free-run, 0 = stop at next period boundary.
- `step`  in  1: one-cycle pulse; requests exactly one tick while stopped.
- `cfg_valid`  in  1: new divisor offered.
- `cfg_div`  in  WIDTH: offered divisor.
- `cfg_ready`  out  1: divisor slot free; transfer when `cfg_valid && cfg_ready`.
- `tick`  out  1: one-cycle clock enable.
- `out`  out  1: square wave, toggles after every tick.
- `running`  out  1: state != STOP.
- `tick_cnt`  out  WIDTH: ticks emitted since reset, wraps.

## Operation
- States: STOP, RUN, STEP, DRAIN. `cnt` counts 0..`div_reg`-1 in every non-STOP state; terminal count (TC) = non-STOP && `cnt == div_reg-1`.
- `tick` = TC (Moore, from registers only). On TC: `cnt` <- 0, `out` toggles, `tick_cnt` increments modulo 2^WIDTH.
- STOP: `cnt` held at 0, `out` held. `run`=1 -> RUN; else `step`=1 -> STEP; both set -> RUN.
- RUN: `run`=0 -> DRAIN (no tick loss; current period completes).
- DRAIN: `run`=1 -> RUN (counting continues, no gap); on TC with `run`=0 -> STOP.
- STEP: on TC -> STOP, unless `run`=1 -> RUN. `step` ignored outside STOP.
- Config: accepted word goes to `shadow` (0 clamped to 1), `pend` <- 1; `cfg_ready` = !`pend`.
- Apply: in STOP, `div_reg` <- `shadow` on the next edge; in other states, at the TC edge (new period uses new divisor). `pend` <- 0 on apply.
- Accept coinciding with TC (`pend` was 0): applied at the following TC, not this one.
- Divisor 1: `tick` high every cycle while active; `out` toggles every cycle.

## Timing
- Reset values: state STOP, `cnt` 0, `div_reg` DEFAULT_DIV, `shadow` 0, `pend` 0, `out` 0, `tick` 0, `running` 0, `tick_cnt` 0, `cfg_ready` 1.
- `run` sampled high at edge N (state STOP): RUN from N; first `tick` in cycle N+`div_reg`-1 counted from the cycle after N, i.e. `div_reg` cycles after the sampling edge; then every `div_reg` cycles.
- `out` period = 2*`div_reg` cycles.
- Step: exactly one tick, `div_reg` cycles after the `step` sample edge; back in STOP the cycle after the tick.
- `cfg_ready` low for exactly one cycle after an accept in STOP; low until next TC when active.
- Reset mid-period: all registers return to reset values immediately; no partial tick.

## Structure
- Shared package `clk_ctrl_pkg`: 2-bit state encoding constants (STOP=0, RUN=1, STEP=2, DRAIN=3), divisor clamp minimum.
- One sub-module `period_counter` (WIDTH, inputs `en`, `clr`, `div`; outputs `cnt`, `tc`); FSM, config shadow and `out`/`tick_cnt` in top.
- Single always_ff for registers, separate combinational next-state logic.

## Test plan
- Reset, DIV=4, `run`=1 for 20 cycles -> `tick` every 4 cycles, first 4 cycles after run sampled, `out` period 8, `tick_cnt`=5.
- DIV=4, drop `run` when `cnt`=1 -> two more cycles, one tick, STOP, `running`=0, `out` held.
- STOP, DIV=3, `step` pulse -> one tick 3 cycles later, STOP next cycle; second `step` during STEP ignored.
- RUN DIV=4, accept `cfg_div`=2 mid-period -> `cfg_ready` low until TC, current period 4, subsequent periods 2.
- `cfg_div`=0 in STOP -> `div_reg`=1, `tick` every cycle once running; `run` and `step` together -> RUN.
- Assert `rst_n` low mid-DRAIN -> all outputs at reset values same cycle, no tick after release until `run`.

Source files
------------

// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the CPU clock run/stop/step controller.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int unsigned DIV_MIN = 1;

endpackage

// File: rtl/period_counter.sv
// Divided-clock period counter: counts 0..div-1 while enabled and flags the terminal count.
module period_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    assign tc = en && (cnt == (div - WIDTH'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/clk_ctrl.sv
// Run/stop/single-step controller for the CPU clock divider with a shadowed, runtime divisor.
module clk_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 25_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             tick,
    output logic             out,
    output logic             running,
    output logic [WIDTH-1:0] tick_cnt
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] div_reg;
    logic [WIDTH-1:0] shadow;
    logic             pend;
    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic             active;
    logic             accept;
    logic             apply;

    assign active    = (state_q != STOP);
    assign accept    = cfg_valid && !pend;
    // A pending divisor lands immediately when stopped, otherwise only at a period boundary.
    assign apply     = pend && (!active || tc);
    assign cfg_ready = !pend;
    assign tick      = tc;

    period_counter #(
        .WIDTH (WIDTH)
    ) u_period_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (active),
        .clr   (!active),
        .div   (div_reg),
        .cnt   (cnt),
        .tc    (tc)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            STOP: begin
                if (run) begin
                    state_d = RUN;
                end else if (step) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (!run) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (run) begin
                    state_d = RUN;
                end else if (tc) begin
                    state_d = STOP;
                end
            end
            STEP: begin
                if (tc) begin
                    state_d = run ? RUN : STOP;
                end
            end
            default: state_d = STOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= STOP;
            running  <= 1'b0;
            div_reg  <= WIDTH'(DEFAULT_DIV);
            shadow   <= '0;
            pend     <= 1'b0;
            out      <= 1'b0;
            tick_cnt <= '0;
        end else begin
            state_q <= state_d;
            running <= (state_d != STOP);
            if (accept) begin
                shadow <= (cfg_div < WIDTH'(DIV_MIN)) ? WIDTH'(DIV_MIN) : cfg_div;
                pend   <= 1'b1;
            end else if (apply) begin
                pend   <= 1'b0;
            end
            if (apply) begin
                div_reg <= shadow;
            end
            if (tc) begin
                out      <= !out;
                tick_cnt <= tick_cnt + WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_clk_ctrl.sv
// Scoreboard bench for clk_ctrl: a cycle model queues expected outputs, compared after each edge.
module tb_clk_ctrl;

    localparam int unsigned W    = 32;
    localparam int unsigned DDIV = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         run;
    logic         step;
    logic         cfg_valid;
    logic [W-1:0] cfg_div;
    logic         cfg_ready;
    logic         tick;
    logic         out;
    logic         running;
    logic [W-1:0] tick_cnt;

    clk_ctrl #(
        .WIDTH       (W),
        .DEFAULT_DIV (DDIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .step      (step),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .tick      (tick),
        .out       (out),
        .running   (running),
        .tick_cnt  (tick_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         tick;
        logic         out;
        logic         running;
        logic         cfg_ready;
        logic [W-1:0] tick_cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   tick_seen = 0;

    // Reference model state (0=STOP 1=RUN 2=STEP 3=DRAIN)
    int           m_st;
    logic [W-1:0] m_cnt;
    logic [W-1:0] m_div;
    logic [W-1:0] m_shadow;
    logic [W-1:0] m_tcnt;
    logic         m_pend;
    logic         m_out;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t m_outputs();
        exp_t e;
        e.tick      = (m_st != 0) && (m_cnt == m_div - 1);
        e.out       = m_out;
        e.running   = (m_st != 0);
        e.cfg_ready = !m_pend;
        e.tick_cnt  = m_tcnt;
        return e;
    endfunction

    task automatic m_reset();
        m_st     = 0;
        m_cnt    = '0;
        m_div    = W'(DDIV);
        m_shadow = '0;
        m_tcnt   = '0;
        m_pend   = 1'b0;
        m_out    = 1'b0;
    endtask

    task automatic m_step(input logic r, input logic s, input logic v, input logic [W-1:0] d);
        logic tc;
        logic apply;
        logic accept;
        int   ns;
        tc     = (m_st != 0) && (m_cnt == m_div - 1);
        apply  = m_pend && ((m_st == 0) || tc);
        accept = v && !m_pend;
        ns     = m_st;
        case (m_st)
            0: if (r) ns = 1; else if (s) ns = 2;
            1: if (!r) ns = 3;
            2: if (tc) ns = r ? 1 : 0;
            default: if (r) ns = 1; else if (tc) ns = 0;
        endcase
        if (m_st == 0 || tc) m_cnt = '0;
        else m_cnt = m_cnt + 1;
        if (apply) m_div = m_shadow;
        if (accept) begin
            m_shadow = (d == 0) ? W'(1) : d;
            m_pend   = 1'b1;
        end else if (apply) begin
            m_pend = 1'b0;
        end
        if (tc) begin
            m_out  = !m_out;
            m_tcnt = m_tcnt + 1;
        end
        m_st = ns;
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", W'(0), W'(1));
        end else begin
            e = sb.pop_front();
            check("tick", W'(tick), W'(e.tick));
            check("out", W'(out), W'(e.out));
            check("running", W'(running), W'(e.running));
            check("cfg_ready", W'(cfg_ready), W'(e.cfg_ready));
            check("tick_cnt", tick_cnt, e.tick_cnt);
            if (tick === 1'b1) tick_seen++;
        end
    endtask

    task automatic cycle(input logic r, input logic s, input logic v, input logic [W-1:0] d);
        @(negedge clk);
        run       = r;
        step      = s;
        cfg_valid = v;
        cfg_div   = d;
        m_step(r, s, v, d);
        sb.push_back(m_outputs());
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        int   t0;
        int   first;
        logic o_saved;

        rst_n = 1'b1;
        run = 1'b0; step = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        sb.push_back(m_outputs());
        compare_out();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Program DIV=4 while stopped, then free-run
        cycle(1'b0, 1'b0, 1'b1, W'(4));
        check("cfg_ready_accept", W'(cfg_ready), W'(0));
        idle(1);
        check("cfg_ready_applied", W'(cfg_ready), W'(1));
        t0 = tick_seen;
        first = -1;
        for (int i = 1; i <= 21; i++) begin
            cycle(1'b1, 1'b0, 1'b0, '0);
            if (first < 0 && tick_seen > t0) first = i;
        end
        check("first_tick_latency", W'(first), W'(4));
        check("run_ticks", W'(tick_seen - t0), W'(5));
        check("run_tick_cnt", tick_cnt, W'(5));

        // Drop run with cnt=1: one more tick, then stop with out held
        cycle(1'b1, 1'b0, 1'b0, '0);
        t0 = tick_seen;
        idle(3);
        check("drain_ticks", W'(tick_seen - t0), W'(1));
        check("drain_stopped", W'(running), W'(0));
        o_saved = out;
        idle(4);
        check("out_held", W'(out), W'(o_saved));

        // Single step at DIV=3 with a second step ignored
        cycle(1'b0, 1'b0, 1'b1, W'(3));
        idle(1);
        t0 = tick_seen;
        first = -1;
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        for (int i = 3; i <= 6; i++) begin
            idle(1);
            if (first < 0 && tick_seen > t0) first = i;
        end
        check("step_latency", W'(first), W'(3));
        check("step_ticks", W'(tick_seen - t0), W'(1));
        check("step_stopped", W'(running), W'(0));

        // Divisor change 4 -> 2 mid-period while running
        cycle(1'b0, 1'b0, 1'b1, W'(4));
        idle(1);
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        t0 = tick_seen;
        cycle(1'b1, 1'b0, 1'b1, W'(2));
        check("cfg_ready_busy", W'(cfg_ready), W'(0));
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0, '0);
        check("retune_ticks", W'(tick_seen - t0), W'(6));

        // Divisor 0 clamps to 1; run and step together enter RUN
        idle(6);
        cycle(1'b0, 1'b0, 1'b1, '0);
        idle(1);
        t0 = tick_seen;
        cycle(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, '0);
        check("div1_ticks", W'(tick_seen - t0), W'(5));
        check("div1_running", W'(running), W'(1));

        // Reset asserted mid-DRAIN
        idle(4);
        cycle(1'b0, 1'b0, 1'b1, W'(4));
        idle(1);
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_reset();
        check("rst_tick", W'(tick), W'(0));
        check("rst_out", W'(out), W'(0));
        check("rst_running", W'(running), W'(0));
        check("rst_cfg_ready", W'(cfg_ready), W'(1));
        check("rst_tick_cnt", tick_cnt, W'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        t0 = tick_seen;
        idle(10);
        check("post_rst_ticks", W'(tick_seen - t0), W'(0));
        check("sb_drained", W'(sb.size()), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
